// File: rtl/avalon_mm_camera_capture.sv
// Camera capture engine: oversampled 8-bit parallel camera -> ping-pong line buffers,
// exposed with control/status registers over an Avalon-MM slave.
module avalon_mm_camera_capture #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned CAM_W    = 8,
  parameter int unsigned ADDR_W   = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 read,
  output logic [2*CAM_W-1:0]   readdata,
  input  logic                 write,
  input  logic [2*CAM_W-1:0]   writedata,
  output logic                 irq,
  input  logic                 PCLK,
  input  logic                 CamHsync,
  input  logic                 CamVsync,
  input  logic [CAM_W-1:0]     CamData_in,
  output logic                 XCLK
);

  localparam int unsigned PW    = 2 * CAM_W;
  localparam int unsigned LW    = 11;
  localparam int unsigned DEPTH = 2 * H_PIXELS;
  localparam int unsigned MAW   = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] A_STAT  = ADDR_W'(DEPTH + 1);
  localparam logic [ADDR_W-1:0] A_LEN   = ADDR_W'(DEPTH + 2);
  localparam logic [ADDR_W-1:0] A_FCNT  = ADDR_W'(DEPTH + 3);
  localparam logic [PW-1:0]     H_PW    = PW'(H_PIXELS);
  localparam logic [MAW-1:0]    H_MA    = MAW'(H_PIXELS);
  localparam logic [LW-1:0]     LAST_LN = LW'(V_LINES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t r_state, w_state_nxt;

  // camera synchronisers and previous sampled values
  logic             r_pclk_s1, r_pclk_s2, r_pclk_q;
  logic             r_href_s1, r_href_s2, r_href_q;
  logic             r_vs_s1, r_vs_s2, r_vs_q;
  logic [CAM_W-1:0] r_data_s1, r_data_s2;

  // capture datapath
  logic             r_in_line, r_drop, r_phase;
  logic [CAM_W-1:0] r_hi;
  logic [PW-1:0]    r_pix_cnt;
  logic [LW-1:0]    r_line_idx;
  logic             r_wr_pend;
  logic [MAW-1:0]   r_wr_addr;
  logic [PW-1:0]    r_wr_data;
  logic [PW-1:0]    r_mem [DEPTH];

  // registers
  logic             r_cont, r_irq_en;
  logic             r_ovf, r_fdone, r_rdy1, r_rdy0;
  logic [LW-1:0]    r_last_line;
  logic [PW-1:0]    r_line_len, r_frame_cnt;
  logic [PW-1:0]    r_readdata;
  logic             r_irq, r_xclk;

  logic w_pclk_rise, w_href_rise, w_href_fall, w_vs_rise, w_vs_fall;
  logic w_ctrl_wr, w_stat_wr, w_start, w_abort, w_busy, w_cap, w_enter_cap;
  logic w_line_start, w_byte, w_line_end, w_buf, w_drop, w_phase;
  logic [PW-1:0] w_pix;
  logic [3:0]    w_clr;
  logic w_set_ovf, w_set_rdy0, w_set_rdy1, w_set_fd;
  logic w_in_buf;
  logic [MAW-1:0] w_rd_idx;
  logic [PW-1:0]  w_status;
  logic w_unused_wd;

  assign w_pclk_rise = r_pclk_s2 & ~r_pclk_q;
  assign w_href_rise = w_pclk_rise & r_href_s2 & ~r_href_q;
  assign w_href_fall = w_pclk_rise & ~r_href_s2 & r_href_q;
  assign w_vs_rise   = w_pclk_rise & r_vs_s2 & ~r_vs_q;
  assign w_vs_fall   = w_pclk_rise & ~r_vs_s2 & r_vs_q;

  assign w_ctrl_wr = write && (address == A_CTRL);
  assign w_stat_wr = write && (address == A_STAT);
  assign w_start   = w_ctrl_wr & writedata[0];
  assign w_abort   = w_ctrl_wr & writedata[3];
  assign w_busy    = (r_state != S_IDLE);
  assign w_clr     = w_stat_wr ? writedata[15:12] : 4'b0000;
  assign w_unused_wd = ^writedata;

  assign w_cap       = (r_state == S_CAPTURE) & ~w_abort;
  assign w_enter_cap = (r_state == S_ARMED) & w_vs_fall & ~w_abort;
  assign w_line_start = w_cap & w_href_rise;
  assign w_byte      = w_cap & w_pclk_rise & r_href_s2 & (r_in_line | w_href_rise);
  assign w_line_end  = w_cap & w_href_fall & r_in_line;
  assign w_buf       = r_line_idx[0];
  // a fresh line samples the target buffer's ready flag to decide whether it is dropped
  assign w_drop      = w_line_start ? (w_buf ? r_rdy1 : r_rdy0) : r_drop;
  assign w_phase     = w_line_start ? 1'b0 : r_phase;
  assign w_pix       = w_line_start ? '0 : r_pix_cnt;

  assign w_set_ovf  = w_line_end & r_drop;
  assign w_set_rdy0 = w_line_end & ~r_drop & ~w_buf;
  assign w_set_rdy1 = w_line_end & ~r_drop & w_buf;
  assign w_set_fd   = (r_state == S_DONE);

  assign w_in_buf = (address < A_CTRL);
  assign w_rd_idx = MAW'(address);
  assign w_status = PW'({r_ovf, r_fdone, r_rdy1, r_rdy0, (r_state == S_CAPTURE), r_last_line});

  assign readdata = r_readdata;
  assign irq      = r_irq;
  assign XCLK     = r_xclk;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // next-state logic; ABORT wins from any state
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (w_start) w_state_nxt = S_ARMED;
        S_ARMED:   if (w_vs_fall) w_state_nxt = S_CAPTURE;
        S_CAPTURE: if ((w_line_end && (r_line_idx == LAST_LN)) || w_vs_rise)
                     w_state_nxt = S_DONE;
        S_DONE:    w_state_nxt = r_cont ? S_ARMED : S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // synchronisers, pixel assembly, line/frame bookkeeping and registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_q <= 1'b0;
      r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_q <= 1'b0;
      r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_q   <= 1'b0;
      r_data_s1 <= '0;   r_data_s2 <= '0;
      r_in_line <= 1'b0; r_drop <= 1'b0; r_phase <= 1'b0;
      r_hi <= '0; r_pix_cnt <= '0; r_line_idx <= '0;
      r_wr_pend <= 1'b0; r_wr_addr <= '0; r_wr_data <= '0;
      r_cont <= 1'b0; r_irq_en <= 1'b0;
      r_ovf <= 1'b0; r_fdone <= 1'b0; r_rdy1 <= 1'b0; r_rdy0 <= 1'b0;
      r_last_line <= '0; r_line_len <= '0; r_frame_cnt <= '0;
      r_irq <= 1'b0; r_xclk <= 1'b0;
    end else begin
      r_wr_pend <= 1'b0;
      r_xclk    <= ~r_xclk;

      r_pclk_s1 <= PCLK;       r_pclk_s2 <= r_pclk_s1; r_pclk_q <= r_pclk_s2;
      r_href_s1 <= CamHsync;   r_href_s2 <= r_href_s1;
      r_vs_s1   <= CamVsync;   r_vs_s2   <= r_vs_s1;
      r_data_s1 <= CamData_in; r_data_s2 <= r_data_s1;
      if (w_pclk_rise) begin
        r_href_q <= r_href_s2;
        r_vs_q   <= r_vs_s2;
      end

      if (w_enter_cap) r_line_idx <= '0;

      if (w_line_start) begin
        r_in_line <= 1'b1;
        r_drop    <= w_drop;
        r_pix_cnt <= '0;
        r_phase   <= 1'b0;
      end

      if (w_byte) begin
        if (!w_phase) begin
          r_hi    <= r_data_s2;
          r_phase <= 1'b1;
        end else begin
          r_phase   <= 1'b0;
          r_pix_cnt <= (w_pix == '1) ? w_pix : w_pix + PW'(1);
          // pixels past the buffer width are counted but never stored
          if (!w_drop && (w_pix < H_PW)) begin
            r_wr_pend <= 1'b1;
            r_wr_addr <= (w_buf ? H_MA : '0) + MAW'(w_pix);
            r_wr_data <= {r_hi, r_data_s2};
          end
        end
      end

      if (w_line_end) begin
        r_in_line  <= 1'b0;
        r_phase    <= 1'b0;
        r_line_idx <= r_line_idx + LW'(1);
        if (!r_drop) begin
          r_last_line <= r_line_idx;
          r_line_len  <= r_pix_cnt;
        end
      end

      if (w_abort || (r_state != S_CAPTURE)) begin
        r_in_line <= 1'b0;
        r_phase   <= 1'b0;
      end
      if (w_abort) r_wr_pend <= 1'b0;

      if (w_ctrl_wr) begin
        r_cont   <= writedata[1];
        r_irq_en <= writedata[2];
      end

      // hardware set takes priority over a same-cycle software clear
      r_ovf   <= (r_ovf   & ~w_clr[3]) | w_set_ovf;
      r_fdone <= (r_fdone & ~w_clr[2]) | w_set_fd;
      r_rdy1  <= (r_rdy1  & ~w_clr[1]) | w_set_rdy1;
      r_rdy0  <= (r_rdy0  & ~w_clr[0]) | w_set_rdy0;

      if (w_set_fd) r_frame_cnt <= r_frame_cnt + PW'(1);

      r_irq <= r_irq_en & (r_rdy0 | r_rdy1 | r_fdone | r_ovf);
    end
  end

  // line buffer write port (contents are not reset)
  always_ff @(posedge clk) begin
    if (r_wr_pend) r_mem[r_wr_addr] <= r_wr_data;
  end

  // registered Avalon read; holds when read is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_readdata <= '0;
    end else if (read) begin
      if (w_in_buf) begin
        r_readdata <= r_mem[w_rd_idx];
      end else begin
        case (address)
          A_CTRL:  r_readdata <= PW'({r_irq_en, r_cont, w_busy});
          A_STAT:  r_readdata <= w_status;
          A_LEN:   r_readdata <= r_line_len;
          A_FCNT:  r_readdata <= r_frame_cnt;
          default: r_readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_avalon_mm_camera_capture.sv
// Bench for avalon_mm_camera_capture: drives camera frames, reads back over Avalon
// and compares against a small behavioural model via a read scoreboard.
module tb_avalon_mm_camera_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int CW = 8;
  localparam int AW = 4;
  localparam logic [AW-1:0] A_CTRL = 4'd8;
  localparam logic [AW-1:0] A_STAT = 4'd9;
  localparam logic [AW-1:0] A_LEN  = 4'd10;
  localparam logic [AW-1:0] A_FCNT = 4'd11;
  localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] address = '0;
  logic          read = 1'b0;
  logic [15:0]   readdata;
  logic          write = 1'b0;
  logic [15:0]   writedata = '0;
  logic          irq;
  logic          PCLK = 1'b0;
  logic          CamHsync = 1'b0;
  logic          CamVsync = 1'b0;
  logic [CW-1:0] CamData_in = '0;
  logic          XCLK;

  always #5 clk = ~clk;

  avalon_mm_camera_capture #(
    .H_PIXELS(H), .V_LINES(V), .CAM_W(CW), .ADDR_W(AW)
  ) u_dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .readdata(readdata),
    .write(write), .writedata(writedata), .irq(irq), .PCLK(PCLK),
    .CamHsync(CamHsync), .CamVsync(CamVsync), .CamData_in(CamData_in), .XCLK(XCLK)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // read scoreboard
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic        rd_d = 1'b0;
  logic [15:0] mon_e;
  string       mon_t;

  always @(posedge clk) rd_d <= read;

  always @(negedge clk) begin
    if (rd_d) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_read", 32'(readdata), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        chk(mon_t, 32'(readdata), 32'(mon_e));
      end
    end
  end

  // behavioural model
  int          m_state, m_idx, m_len, m_last, m_fcnt;
  bit [1:0]    m_rdy;
  bit          m_ovf, m_fd, m_cont, m_ien;
  logic [15:0] mm [2*H];

  task automatic model_reset();
    m_state = M_IDLE; m_idx = 0; m_len = 0; m_last = 0; m_fcnt = 0;
    m_rdy = 2'b00; m_ovf = 1'b0; m_fd = 1'b0; m_cont = 1'b0; m_ien = 1'b0;
  endtask

  function automatic logic [15:0] exp_status();
    return {m_ovf, m_fd, m_rdy[1], m_rdy[0], (m_state == M_CAP), 11'(m_last)};
  endfunction

  function automatic logic [15:0] exp_ctrl();
    return {13'd0, m_ien, m_cont, (m_state != M_IDLE)};
  endfunction

  task automatic frame_done();
    m_fd = 1'b1;
    m_fcnt = (m_fcnt + 1) & 16'hFFFF;
    m_state = m_cont ? M_ARMED : M_IDLE;
  endtask

  // Avalon accesses
  task automatic rd(input logic [AW-1:0] a, input logic [15:0] e, input string tag);
    @(negedge clk);
    address = a; read = 1'b1;
    exp_q.push_back(e); tag_q.push_back(tag);
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; writedata = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic ctrl_write(input logic [15:0] d);
    wr(A_CTRL, d);
    m_cont = d[1]; m_ien = d[2];
    if (d[3]) m_state = M_IDLE;
    else if (d[0] && m_state == M_IDLE) m_state = M_ARMED;
  endtask

  task automatic stat_clear(input logic [3:0] c);
    wr(A_STAT, {c, 12'd0});
    if (c[3]) m_ovf = 1'b0;
    if (c[2]) m_fd = 1'b0;
    if (c[1]) m_rdy[1] = 1'b0;
    if (c[0]) m_rdy[0] = 1'b0;
  endtask

  task automatic check_regs(input string pfx);
    rd(A_CTRL, exp_ctrl(),        {pfx, "_ctrl"});
    rd(A_STAT, exp_status(),      {pfx, "_status"});
    rd(A_LEN,  16'(m_len),        {pfx, "_line_len"});
    rd(A_FCNT, 16'(m_fcnt),       {pfx, "_frame_cnt"});
  endtask

  task automatic check_buf(input string pfx, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) rd(AW'(i), mm[i], $sformatf("%s_buf%0d", pfx, i));
  endtask

  // camera: one PCLK period = 8 clk, signals change while PCLK is low
  task automatic pclk_cycle(input logic href, input logic vs, input logic [CW-1:0] d);
    @(negedge clk);
    PCLK = 1'b0; CamHsync = href; CamVsync = vs; CamData_in = d;
    repeat (3) @(negedge clk);
    PCLK = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_begin();
    pclk_cycle(1'b0, 1'b1, 8'h00);
    pclk_cycle(1'b0, 1'b1, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    pclk_cycle(1'b0, 1'b0, 8'h00);
    if (m_state == M_ARMED) begin
      m_state = M_CAP; m_idx = 0;
    end
  endtask

  task automatic frame_end();
    pclk_cycle(1'b0, 1'b1, 8'h00);
    if (m_state == M_CAP) frame_done();
  endtask

  task automatic send_line(input int base, input int n);
    int          b;
    bit          cap, drop;
    logic [7:0]  d, prev;
    b = m_idx % 2;
    cap = (m_state == M_CAP);
    drop = m_rdy[b];
    prev = 8'h00;
    for (int i = 0; i < n; i++) begin
      d = 8'(base + i);
      pclk_cycle(1'b1, 1'b0, d);
      if (cap && !drop && (i % 2 == 1) && (i / 2 < H)) mm[b*H + i/2] = {prev, d};
      prev = d;
    end
    pclk_cycle(1'b0, 1'b0, 8'h00);
    if (cap) begin
      if (drop) m_ovf = 1'b1;
      else begin
        m_rdy[b] = 1'b1; m_len = n / 2; m_last = m_idx;
      end
      m_idx++;
      if (m_idx == V) frame_done();
    end
    pclk_cycle(1'b0, 1'b0, 8'h00);
  endtask

  logic x1, x2;

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    chk("rst_readdata", 32'(readdata), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_xclk", 32'(XCLK), 0);
    reset = 1'b1;
    @(negedge clk); x1 = XCLK;
    @(negedge clk); x2 = XCLK;
    chk("xclk_toggle", 32'(x1 ^ x2), 1);
    check_regs("rst");

    // single-shot frame
    ctrl_write(16'h0001);
    rd(A_CTRL, exp_ctrl(), "s1_busy");
    frame_begin();
    send_line(8'h01, 8);
    check_buf("s1", 0, 3);
    rd(A_STAT, exp_status(), "s1_status_mid");
    rd(A_LEN, 16'(m_len), "s1_len");
    chk("s1_irq", 32'(irq), 0);
    send_line(8'h11, 8);
    frame_end();
    check_buf("s1b", 4, 7);
    check_regs("s1_end");

    // interrupts enabled
    stat_clear(4'hF);
    ctrl_write(16'h0005);
    frame_begin();
    send_line(8'h41, 8);
    send_line(8'h51, 8);
    frame_end();
    chk("s2_irq_set", 32'(irq), 1);
    check_regs("s2");
    check_buf("s2", 0, 7);
    wr(A_STAT, 16'hF000);
    m_ovf = 0; m_fd = 0; m_rdy = 2'b00;
    chk("s2_irq_delay", 32'(irq), 1);
    @(negedge clk);
    chk("s2_irq_clr", 32'(irq), 0);
    rd(A_STAT, exp_status(), "s2_status_clr");

    // continuous mode, overflow on line 2
    ctrl_write(16'h0003);
    frame_begin();
    send_line(8'h61, 8);
    send_line(8'h71, 8);
    frame_end();
    rd(A_CTRL, exp_ctrl(), "s3_rearmed");
    frame_begin();
    send_line(8'h81, 8);
    frame_end();
    check_buf("s3", 0, 7);
    check_regs("s3");
    ctrl_write(16'h0008);
    rd(A_CTRL, exp_ctrl(), "s3_abort");

    // long line with odd trailing byte
    stat_clear(4'hF);
    ctrl_write(16'h0001);
    frame_begin();
    send_line(8'h91, 13);
    frame_end();
    check_buf("s4", 0, 7);
    check_regs("s4");

    // abort mid-line, flags retained, then a clean frame
    ctrl_write(16'h0001);
    frame_begin();
    for (int i = 0; i < 3; i++) pclk_cycle(1'b1, 1'b0, 8'(8'hA1 + i));
    ctrl_write(16'h0008);
    rd(A_CTRL, exp_ctrl(), "s5_busy_after_abort");
    pclk_cycle(1'b0, 1'b0, 8'h00);
    rd(A_STAT, exp_status(), "s5_flags_kept");
    stat_clear(4'hF);
    ctrl_write(16'h0001);
    frame_begin();
    send_line(8'hB1, 8);
    send_line(8'hC1, 8);
    frame_end();
    check_buf("s5", 0, 7);
    check_regs("s5");

    // reset pulse in the middle of capture
    stat_clear(4'hF);
    ctrl_write(16'h0001);
    frame_begin();
    send_line(8'h21, 8);
    for (int i = 0; i < 4; i++) pclk_cycle(1'b1, 1'b0, 8'(8'h31 + i));
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    model_reset();
    chk("s6_irq", 32'(irq), 0);
    check_regs("s6_rst");
    pclk_cycle(1'b0, 1'b0, 8'h00);
    frame_end();
    ctrl_write(16'h0001);
    frame_begin();
    send_line(8'h01, 8);
    check_buf("s6", 0, 3);
    check_regs("s6");

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
